fetch_ctrl: RTL

- Instruction-fetch sequencer in front of the combinational instruction memory.
- Owns the program counter and drives the memory address every cycle.
- Captures each returned word with its PC into a small FIFO, then presents {pc, instr} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute and flushes in-flight fetches.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int          FETCH_XLEN  = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush discards everything.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer tells full from empty when the indices match.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    fetch_entry_t mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
    end

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, walks instruction memory and buffers {pc, instr} for decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int             XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int             FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    fetch_entry_t    hold_q;
    fetch_entry_t    fifo_head, fifo_entry, head_sel;
    logic            fifo_full, fifo_empty;
    logic            push, pop;

    assign if_valid   = !fifo_empty;
    assign pop        = if_valid && if_ready;
    assign push       = (state_q == RUN) && !redirect_valid && (!fifo_full || pop);
    assign fifo_entry = '{pc: pc_q, instr: imem_instr};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .entry_i (fifo_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            // A redirect while draining abandons the drain outright.
            state_d = (state_q == DRAIN) ? IDLE : state_q;
        end else begin
            if (push) pc_d = pc_q + XLEN'(INSTR_BYTES);
            case (state_q)
                IDLE:    if (fetch_en) state_d = RUN;
                RUN:     if (!fetch_en) state_d = DRAIN;
                DRAIN: begin
                    if (fetch_en)        state_d = RUN;
                    else if (fifo_empty) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (!fifo_empty) hold_q <= fifo_head;
        end
    end

    // Head outputs keep the last shown entry once the buffer empties.
    assign head_sel  = fifo_empty ? hold_q : fifo_head;
    assign if_pc     = head_sel.pc;
    assign if_instr  = head_sel.instr;
    assign imem_addr = pc_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule
